// File: rtl/prf_mp.sv
// Multi-ported physical register file: N writeback, N invalidate and N read ports.
// Same-cycle writeback bypass, flush valid recovery and a sticky collision flag.
module prf_mp #(
   parameter int XLEN_P   = 32,
   parameter int N_PHYS   = 128,
   parameter int N_ARCH   = 32,
   parameter int TAG_W    = 7,
   parameter int NUM_READ = 4,
   parameter int NUM_WB   = 2,
   parameter int NUM_INV  = 2,
   parameter bit BYPASS   = 1'b1
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NUM_INV-1:0]                 inv_valid_i,
   input  logic [NUM_INV-1:0][TAG_W-1:0]      inv_tag_i,
   input  logic [NUM_WB-1:0]                  wb_valid_i,
   input  logic [NUM_WB-1:0][TAG_W-1:0]       wb_tag_i,
   input  logic [NUM_WB-1:0][XLEN_P-1:0]      wb_data_i,
   input  logic                               flush_i,
   input  logic [N_PHYS-1:0]                  flush_mask_i,
   input  logic [NUM_READ-1:0][TAG_W-1:0]     rtag_i,
   output logic [NUM_READ-1:0][XLEN_P-1:0]    rdata_o,
   output logic [NUM_READ-1:0]                rready_o,
   output logic [N_PHYS-1:0]                  valid_o,
   output logic                               wb_conflict_o
);

   localparam logic [TAG_W:0] LIM = (TAG_W+1)'(N_PHYS);

   logic [N_PHYS-1:0][XLEN_P-1:0] r_mem;
   logic [N_PHYS-1:0]             r_valid;
   logic                          r_conflict;
   logic                          w_collide;

   // Nonzero, in-range tag: the only tags that touch storage.
   function automatic logic f_ok(input logic [TAG_W-1:0] t);
      return (t != '0) && ({1'b0, t} < LIM);
   endfunction

   always_comb begin
      w_collide = 1'b0;
      for (int p = 0; p < NUM_WB; p++)
         for (int q = p + 1; q < NUM_WB; q++)
            if (wb_valid_i[p] && wb_valid_i[q] &&
                wb_tag_i[p] == wb_tag_i[q] && wb_tag_i[p] != '0)
               w_collide = 1'b1;
   end

   // Later assignments win: invalidate < flush < writeback, high port last.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N_PHYS; i++) begin
            r_mem[i]   <= '0;
            r_valid[i] <= (i < N_ARCH) || (i == 0);
         end
         r_conflict <= 1'b0;
      end else begin
         if (!flush_i)
            for (int k = 0; k < NUM_INV; k++)
               if (inv_valid_i[k] && f_ok(inv_tag_i[k]))
                  r_valid[inv_tag_i[k]] <= 1'b0;
         if (flush_i)
            for (int i = 1; i < N_PHYS; i++)
               if (flush_mask_i[i])
                  r_valid[i] <= 1'b1;
         for (int p = 0; p < NUM_WB; p++)
            if (wb_valid_i[p] && f_ok(wb_tag_i[p])) begin
               r_mem[wb_tag_i[p]]   <= wb_data_i[p];
               r_valid[wb_tag_i[p]] <= 1'b1;
            end
         r_conflict <= r_conflict | w_collide;
      end
   end

   always_comb begin
      for (int r = 0; r < NUM_READ; r++) begin
         rdata_o[r]  = '0;
         rready_o[r] = 1'b0;
         if (rtag_i[r] == '0) begin
            rready_o[r] = 1'b1;
         end else if (f_ok(rtag_i[r])) begin
            rdata_o[r]  = r_mem[rtag_i[r]];
            rready_o[r] = r_valid[rtag_i[r]];
            if (BYPASS)
               for (int p = 0; p < NUM_WB; p++)
                  if (wb_valid_i[p] && wb_tag_i[p] == rtag_i[r]) begin
                     rdata_o[r]  = wb_data_i[p];
                     rready_o[r] = 1'b1;
                  end
         end
      end
   end

   assign valid_o       = r_valid;
   assign wb_conflict_o = r_conflict;

endmodule
